// File: rtl/fpu_adder_pkg.sv
// rtl/fpu_adder_pkg.sv - shared op encodings and sizing helper for the FPU add datapath
package fpu_adder_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDC = 2'b10;
    localparam logic [1:0] OP_SUBB = 2'b11;

    // Number of prefix levels; never below one so a 2-bit adder still has a level.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prefix_level.sv
// rtl/prefix_level.sv - one combinational Kogge-Stone generate/propagate level
module prefix_level #(
    parameter int N    = 32,
    parameter int DIST = 1
) (
    input  logic [N-1:0] g_in,
    input  logic [N-1:0] p_in,
    output logic [N-1:0] g_out,
    output logic [N-1:0] p_out
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
            assign p_out[i] = p_in[i] & p_in[i-DIST];
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - pipelined Kogge-Stone add/sub with NZCV flags, tag and flush
module pipelined_prefix_adder
    import fpu_adder_pkg::*;
#(
    parameter int N          = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic [TAG_W-1:0] tag_out,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int L   = clog2_min1(N);
    localparam int NG  = (L + PIPE_EVERY - 1) / PIPE_EVERY;
    localparam int LAT = NG + 1;

    logic [N-1:0] bx, g0, p0;
    logic         c0;

    always_comb begin
        bx = op[0] ? ~B : B;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            default: c0 = cin;
        endcase
        p0    = A ^ bx;
        g0    = A & bx;
        g0[0] = (A[0] & bx[0]) | (p0[0] & c0);
    end

    // Stage s holds the generate/propagate state after s*PIPE_EVERY levels.
    logic [N-1:0]     g_q   [NG];
    logic [N-1:0]     p_q   [NG];
    logic [N-1:0]     p0_q  [NG];
    logic             c0_q  [NG];
    logic [TAG_W-1:0] tag_q [NG];
    logic [N-1:0]     g_lvl [1:L];
    logic [N-1:0]     p_lvl [1:L];

    for (genvar k = 1; k <= L; k++) begin : g_level
        logic [N-1:0] g_src, p_src;
        if ((k - 1) % PIPE_EVERY == 0) begin : g_from_reg
            assign g_src = g_q[(k-1)/PIPE_EVERY];
            assign p_src = p_q[(k-1)/PIPE_EVERY];
        end else begin : g_from_level
            assign g_src = g_lvl[k-1];
            assign p_src = p_lvl[k-1];
        end
        prefix_level #(.N(N), .DIST(1 << (k - 1))) u_level (
            .g_in  (g_src),
            .p_in  (p_src),
            .g_out (g_lvl[k]),
            .p_out (p_lvl[k])
        );
    end

    logic unused_p_final;
    assign unused_p_final = ^p_lvl[L];

    logic [LAT-1:0] v, adv, ld;
    logic           room;

    // Walk back from the output: a stage advances if valid and the next stage has room.
    always_comb begin
        room = out_ready;
        adv  = '0;
        for (int s = LAT - 1; s >= 0; s--) begin
            adv[s] = v[s] & room;
            room   = ~v[s] | adv[s];
        end
    end

    assign in_ready  = rst_n & ~flush & room;
    assign ld        = {adv[LAT-2:0], in_valid & in_ready};
    assign out_valid = v[LAT-1];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            v <= ld | (v & ~adv);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (ld[0]) begin
            g_q[0]   <= g0;
            p_q[0]   <= p0;
            p0_q[0]  <= p0;
            c0_q[0]  <= c0;
            tag_q[0] <= tag_in;
        end
        for (int s = 1; s < NG; s++) begin
            if (ld[s]) begin
                g_q[s]   <= g_lvl[s*PIPE_EVERY];
                p_q[s]   <= p_lvl[s*PIPE_EVERY];
                p0_q[s]  <= p0_q[s-1];
                c0_q[s]  <= c0_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    logic [N:0]   carry;
    logic [N-1:0] sum_c;

    assign carry = {g_lvl[L], c0_q[NG-1]};
    assign sum_c = p0_q[NG-1] ^ carry[N-1:0];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            tag_out <= '0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else if (ld[LAT-1]) begin
            sum     <= sum_c;
            tag_out <= tag_q[NG-1];
            flag_c  <= carry[N];
            flag_v  <= carry[N] ^ carry[N-1];
            flag_z  <= ~|sum_c;
            flag_n  <= sum_c[N-1];
        end
    end

endmodule
